uart_rx: RTL
============

# uart_rx

UART receiver consuming the 16x `oversample_tick` from the baud generator. It synchronises the asynchronous serial line and qualifies the start bit at mid-bit. Data bits are sampled at bit centres, with optional parity and stop-bit checks. Each received byte goes to the downstream consumer over a valid/ready handshake with one holding register.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first
- `PARITY_EN`, 0: 1 = a parity bit follows the data bits
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN`=0
- Reset and clock: reset `reset`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  system clock, same clock as the baud generator
- `reset`  in  1  asynchronous active-high reset
- `oversample_tick`  in  1  one-`clk` pulse at 16x baud
- `rx`  in  1  asynchronous serial line, idle high
- `rx_data`  out  DATA_BITS  received word, valid while `rx_valid`=1
- `rx_valid`  out  1  word available; held until accepted
- `rx_ready`  in  1  consumer accepts the word when `rx_valid`&`rx_ready`
- `frame_err`  out  1  stop bit sampled 0; qualified by `rx_valid`
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`, always 0 when `PARITY_EN`=0
- `overrun`  out  1  one-`clk` pulse when a completed frame is dropped

## Operation
- `rx` passes through a 2-FF synchroniser to give `rx_s`. Both flops reset to 1.
- All FSM and counter updates occur only on `clk` edges where `oversample_tick`=1. Handshake logic runs every `clk`.
- The 4-bit tick counter `cnt` and the bit index `idx` clear on each state entry.
- States and transitions:
  - IDLE: on a tick with `rx_s`=0 -> START, `cnt`=0.
  - START: on each tick `cnt`++. At the tick where `cnt`==7 (mid start bit):
    - `rx_s`=0 -> DATA.
    - `rx_s`=1 -> IDLE. This is a glitch; nothing is reported.
  - DATA: at `cnt`==15, shift `rx_s` into the shift register MSB-ward (LSB received first) and increment `idx`. After bit DATA_BITS-1 -> PARITY if `PARITY_EN`, else STOP.
  - PARITY: at `cnt`==15, sample the parity bit. The error flag is XOR(data, parity bit) != `PARITY_ODD`.
  - STOP: at `cnt`==15, sample the stop bit and complete the frame.
    - `rx_s`=1 -> IDLE.
    - `rx_s`=0 -> sets `frame_err`; go to BREAK.
  - BREAK: stay until a tick with `rx_s`=1, then IDLE.
- Frame completion:
  - If the holding register is empty, or is being accepted in the same `clk`: load `rx_data` and both error flags, and set `rx_valid`.
  - Otherwise: drop the frame, keep the held word and flags, pulse `overrun`.
- Frames with errors are still delivered; the error flags are attached to that word.
- `rx_valid`&`rx_ready` with no completion in the same cycle clears `rx_valid` on the next edge. `rx_data` keeps its value.
- Reset mid-frame returns to IDLE immediately and discards the partial frame.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0. The state is IDLE.
- Sampling points after the first low tick: start at tick 7, bit *k* at tick 7+16(k+1), parity and stop follow at the same 16-tick spacing. This yields centre-of-bit sampling within ±1 tick.
- Input latency: 2 `clk` through the synchroniser, plus up to 1 tick period of start detection.
- Output latency: `rx_valid` rises on the `clk` edge that processes the stop-bit sampling tick. All outputs are registered.
- Throughput: back-to-back frames are supported. IDLE is re-entered at mid-stop, allowing 0.5 bit of tolerance for the next start edge.
- `overrun` is high for exactly 1 `clk`.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `OVERSAMPLE`=16;
  - `MID_SAMPLE`=7.
- One sub-module, `sync_2ff`: a parameterised-reset-value 2-flop synchroniser, reused by future UART inputs.
- Estimated size: ~180 lines total RTL.

## Test plan
Bench configuration: `baud_gen` with CLK_FREQ=50 MHz, BAUD=115200, giving 27 `clk` per tick. Defaults unless noted.

- Send 0xA5 (8N1) with `rx_ready`=1 -> `rx_valid` for 1 `clk`, `rx_data`=0xA5, both error flags 0.
- Send 0x3C then 0xC3 back-to-back with `rx_ready`=0 -> the first word holds 0x3C and `overrun` pulses once. After `rx_ready`, `rx_valid` drops and `rx_data` stays 0x3C.
- Send 0x55 with the stop bit forced 0, then hold the line low for 3 bit times, then release, then send 0x01:
  - first frame: `rx_data`=0x55 with `frame_err`=1;
  - no frame is produced during the low period;
  - second frame: 0x01 with `frame_err`=0.
- Apply a low glitch of 4 ticks on an idle line -> no `rx_valid`, and the FSM returns to IDLE.
- With `PARITY_EN`=1, `PARITY_ODD`=0:
  - send 0x07 with parity bit 1 -> `parity_err`=0;
  - resend with parity bit 0 -> `parity_err`=1, `rx_data`=0x07.
- Assert `reset` during bit 4 of a frame -> all outputs are 0. The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP,
    S_BREAK  = ST_BREAK
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reset value chosen per input (idle level).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with optional parity, break handling and a
// single-word valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 oversample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  logic rx_s;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d, cnt_inc;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done;
  logic                 accept;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    frame_done   = 1'b0;
    cnt_inc      = cnt_q + 4'd1;
    accept       = rx_valid_q & rx_ready;

    if (oversample_tick) begin
      // Counter wraps 15 -> 0, so each bit slot restarts the count by itself.
      cnt_d = cnt_inc;
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          if (!rx_s) state_d = S_START;
        end
        S_START: begin
          if (cnt_inc == 4'(MID_SAMPLE)) begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q == 4'(OVERSAMPLE - 1)) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'(DATA_BITS - 1)) begin
              idx_d   = '0;
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (cnt_q == 4'(OVERSAMPLE - 1)) begin
            par_err_d = ((^shift_q) ^ rx_s) != (PARITY_ODD != 0);
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          if (cnt_q == 4'(OVERSAMPLE - 1)) begin
            frame_done = 1'b1;
            state_d    = rx_s ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          cnt_d = '0;
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A completing frame may replace a word that is being accepted this cycle.
    if (frame_done) begin
      if (!rx_valid_q || accept) begin
        rx_data_d    = shift_q;
        frame_err_d  = ~rx_s;
        parity_err_d = (PARITY_EN != 0) & par_err_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule
